sample_queue: RTL and testbench

SAMPLE_QUEUE -- requirements
Module: sample_queue

---
 rtl/eq_pkg.sv | 14 +
 rtl/dp_ram_queue.sv | 30 +++
 rtl/sample_queue.sv | 122 ++++++++++++
 tb/tb_sample_queue.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared parameters and types for the stereo sample queue feeding the FIR stage.
// The module-level DEPTH/SEQ_LEN parameters default to the values here.
package eq_pkg;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned SEQ_LEN = 1021;
  localparam int unsigned AW      = $clog2(DEPTH);

  typedef enum logic {
    StIdle,
    StRead
  } state_e;

endpackage

// File: rtl/dp_ram_queue.sv
// Simple dual-port sample storage: synchronous write, registered read, no reset on contents.
module dp_ram_queue #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sample_queue.sv
// Circular stereo sample queue: after each qualifying write, replays the newest SEQ_LEN
// samples oldest-first as one burst, with sequencing framing the valid output data.
module sample_queue
  import eq_pkg::*;
#(
  parameter int unsigned DEPTH   = eq_pkg::DEPTH,
  parameter int unsigned SEQ_LEN = eq_pkg::SEQ_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        sequencing,
  output logic        overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] CntFull  = AW'(SEQ_LEN);
  localparam logic [AW-1:0] LastRead = AW'(SEQ_LEN - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] new_ptr_q, new_ptr_d;
  logic [AW-1:0] old_ptr_q, old_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] burst_cnt_q, burst_cnt_d;
  logic          overrun_q, overrun_d;
  logic          rd_issue;
  logic          seq_q;
  logic [31:0]   rd_data;

  // Pointers rely on DEPTH being a power of two, so increments wrap for free.
  always_comb begin
    state_d     = state_q;
    new_ptr_d   = new_ptr_q;
    old_ptr_d   = old_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    burst_cnt_d = burst_cnt_q;
    overrun_d   = overrun_q;
    rd_issue    = 1'b0;

    if (wrt_smpl) begin
      new_ptr_d = new_ptr_q + 1'b1;
      if (count_q == CntFull) begin
        old_ptr_d = old_ptr_q + 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (wrt_smpl && (count_d == CntFull)) begin
          state_d     = StRead;
          rd_ptr_d    = old_ptr_d;
          burst_cnt_d = '0;
        end
      end
      StRead: begin
        rd_issue = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (burst_cnt_q == LastRead) begin
          state_d = StIdle;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        // Writes still land; they just cannot restart or stretch the burst.
        if (wrt_smpl) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      new_ptr_q   <= '0;
      old_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      burst_cnt_q <= '0;
      overrun_q   <= 1'b0;
      seq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      new_ptr_q   <= new_ptr_d;
      old_ptr_q   <= old_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      burst_cnt_q <= burst_cnt_d;
      overrun_q   <= overrun_d;
      seq_q       <= rd_issue;
    end
  end

  dp_ram_queue #(
    .DEPTH (DEPTH),
    .WIDTH (32),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wrt_smpl),
    .waddr (new_ptr_q),
    .wdata ({lft_smpl, rght_smpl}),
    .re    (rd_issue),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // RAM output register is not reset, so gate it with the aligned read flag.
  assign sequencing = seq_q;
  assign lft_out    = seq_q ? rd_data[31:16] : 16'h0000;
  assign rght_out   = seq_q ? rd_data[15:0]  : 16'h0000;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sample_queue.sv
// Directed bench for sample_queue: fill, first burst, discard/wrap, overrun and mid-burst reset.
module tb_sample_queue;

  localparam int SeqLen = 1021;

  logic        clk;
  logic        rst_n;
  logic        wrt_smpl;
  logic [15:0] lft_smpl;
  logic [15:0] rght_smpl;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
  logic        sequencing;
  logic        overrun;

  int n_checks;
  int n_errors;

  sample_queue #(
    .DEPTH   (1024),
    .SEQ_LEN (SeqLen)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .sequencing (sequencing),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs,
               $signed(exp), exp);
    end
  endtask

  // Advance one clock; inputs and outputs are touched 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int n);
    wrt_smpl  = 1'b1;
    lft_smpl  = 16'(n);
    rght_smpl = 16'(-n);
    tick();
    wrt_smpl  = 1'b0;
  endtask

  // Called right after do_write: expects the burst to open one cycle later.
  // inj >= 0 plants a write with value inj_val at that burst index.
  task automatic check_burst(input string tag, input int first, input int inj,
                             input int inj_val);
    check({tag, "_pre_seq"}, 32'(sequencing), 32'd0);
    for (int i = 0; i < SeqLen; i++) begin
      if (i == inj) begin
        wrt_smpl  = 1'b1;
        lft_smpl  = 16'(inj_val);
        rght_smpl = 16'(-inj_val);
      end
      tick();
      wrt_smpl = 1'b0;
      check({tag, "_seq"}, 32'(sequencing), 32'd1);
      check({tag, "_lft"}, 32'($signed(lft_out)), 32'(first + i));
      check({tag, "_rght"}, 32'($signed(rght_out)), 32'(-(first + i)));
    end
    tick();
    check({tag, "_post_seq"}, 32'(sequencing), 32'd0);
    check({tag, "_post_lft"}, 32'(lft_out), 32'd0);
  endtask

  // Feed cnt back-to-back writes starting at base, counting any sign of activity.
  task automatic fill(input string tag, input int base, input int cnt);
    int seen = 0;
    for (int n = 0; n < cnt; n++) begin
      do_write(base + n);
      if (sequencing || lft_out != 16'h0 || rght_out != 16'h0) seen++;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (sequencing || lft_out != 16'h0 || rght_out != 16'h0) seen++;
    end
    check({tag, "_quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    wrt_smpl  = 1'b0;
    lft_smpl  = '0;
    rght_smpl = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_seq", 32'(sequencing), 32'd0);
    check("rst_lft", 32'(lft_out), 32'd0);
    check("rst_rght", 32'(rght_out), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // 1020 writes: one short of a full window.
    fill("fill1020", 0, SeqLen - 1);

    do_write(1020);
    check_burst("burst0", 0, -1, 0);

    do_write(1021);
    check_burst("burst1", 1, -1, 0);

    // Writes 1022..1029; the last burst crosses address 1023 -> 0.
    for (int n = 1022; n < 1030; n++) begin
      do_write(n);
      check_burst($sformatf("burst_w%0d", n), n - 1020, -1, 0);
    end
    check("no_ovr", 32'(overrun), 32'd0);

    // Write 500 cycles into a burst: burst unchanged, overrun sticky, no retrigger.
    do_write(1030);
    check_burst("ovr_burst", 10, 500, 1031);
    check("ovr_flag", 32'(overrun), 32'd1);
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (sequencing) seen++;
      end
      check("ovr_no_retrig", 32'(seen), 32'd0);
    end
    do_write(1032);
    check_burst("after_ovr", 12, -1, 0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-burst.
    do_write(1033);
    for (int k = 0; k < 100; k++) tick();
    check("mid_seq_hi", 32'(sequencing), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_seq", 32'(sequencing), 32'd0);
    check("mrst_lft", 32'(lft_out), 32'd0);
    check("mrst_rght", 32'(rght_out), 32'd0);
    check("mrst_ovr", 32'(overrun), 32'd0);
    fill("mrst_fill", 2000, SeqLen - 1);
    do_write(2000 + SeqLen - 1);
    check_burst("mrst_burst", 2000, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
